// File: rtl/sps_layer_sequencer_pkg.sv
// Shared types for the SPS layer sequencer: FSM state encoding and the
// descriptor layout (field widths and bit positions fixed by the packed struct).
package sps_layer_sequencer_pkg;

  localparam int FIELD_W = 16;
  localparam int IDX_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Bit 80 is_maxpool, then lif_thrd [79:64], bias_scale [63:48],
  // in_ch [47:32], out_ch [31:16], img_size [15:0].
  typedef struct packed {
    logic               is_maxpool;
    logic [FIELD_W-1:0] lif_thrd;
    logic [FIELD_W-1:0] bias_scale;
    logic [FIELD_W-1:0] in_ch;
    logic [FIELD_W-1:0] out_ch;
    logic [FIELD_W-1:0] img_size;
  } desc_t;

  // A layer with no input channels, no image or (conv) no output channels
  // cannot be run and is skipped.
  function automatic logic desc_invalid(input desc_t d);
    return (d.in_ch == '0) || (d.img_size == '0) ||
           (!d.is_maxpool && (d.out_ch == '0));
  endfunction

endpackage

// File: rtl/sps_layer_sequencer_if.sv
// Descriptor request bus between the code-fetch ROM front end (master) and
// the layer sequencer (slave).
interface sps_layer_sequencer_if;
  import sps_layer_sequencer_pkg::*;

  // Handshake: a descriptor transfers in a cycle where o_code_ready and
  // i_code_valid are both high; valid seen while ready is low carries nothing.
  logic               o_code_ready;
  logic               i_code_valid;
  logic               i_fetch_done;
  logic               i_is_maxpool;
  logic [FIELD_W-1:0] i_lif_thrd;
  logic [FIELD_W-1:0] i_bias_scale;
  logic [FIELD_W-1:0] i_in_ch;
  logic [FIELD_W-1:0] i_out_ch;
  logic [FIELD_W-1:0] i_img_size;

  modport master (
    input  o_code_ready,
    output i_code_valid, i_fetch_done, i_is_maxpool, i_lif_thrd,
           i_bias_scale, i_in_ch, i_out_ch, i_img_size
  );

  modport slave (
    output o_code_ready,
    input  i_code_valid, i_fetch_done, i_is_maxpool, i_lif_thrd,
           i_bias_scale, i_in_ch, i_out_ch, i_img_size
  );

endinterface

// File: rtl/sps_layer_sequencer_oc_pass_ctrl.sv
// Output-channel pass counter: tracks the first channel of the current pass
// and the size of that pass, including the short remainder pass.
module sps_layer_sequencer_oc_pass_ctrl
  import sps_layer_sequencer_pkg::*;
#(
  parameter int OC_PER_PASS = 8
) (
  input  logic               s_clk,
  input  logic               s_rst,
  input  logic               load,
  input  logic               advance,
  input  logic               is_maxpool,
  input  logic [FIELD_W-1:0] out_ch,
  output logic [FIELD_W-1:0] oc_base,
  output logic [FIELD_W-1:0] oc_num,
  output logic               more_passes
);

  localparam logic [FIELD_W:0] STEP = (FIELD_W+1)'(OC_PER_PASS);

  logic [FIELD_W:0] next_base;
  logic [FIELD_W:0] remain;

  always_ff @(posedge s_clk) begin
    if (s_rst || load) begin
      oc_base <= '0;
    end else if (advance) begin
      oc_base <= next_base[FIELD_W-1:0];
    end
  end

  // One extra bit keeps base + step from wrapping when out_ch is near 0xFFFF.
  always_comb begin
    next_base   = {1'b0, oc_base} + STEP;
    remain      = {1'b0, out_ch} - {1'b0, oc_base};
    more_passes = !is_maxpool && (next_base < {1'b0, out_ch});
    oc_num      = STEP[FIELD_W-1:0];
    if (is_maxpool) begin
      oc_num = out_ch;
    end else if (remain < STEP) begin
      oc_num = remain[FIELD_W-1:0];
    end
  end

endmodule

// File: rtl/sps_layer_sequencer.sv
// SPS layer sequencer: fetches layer descriptors, splits conv layers into
// output-channel passes and launches the compute engine once per pass.
module sps_layer_sequencer
  import sps_layer_sequencer_pkg::*;
#(
  parameter int OC_PER_PASS = 8,
  parameter int MAX_LAYERS  = 32
) (
  input  logic                 s_clk,
  input  logic                 s_rst,
  input  logic                 i_sps_start,
  output logic                 o_busy,
  sps_layer_sequencer_if.slave code,
  output logic                 o_is_maxpool,
  output logic [FIELD_W-1:0]   o_lif_thrd,
  output logic [FIELD_W-1:0]   o_bias_scale,
  output logic [FIELD_W-1:0]   o_in_ch,
  output logic [FIELD_W-1:0]   o_out_ch,
  output logic [FIELD_W-1:0]   o_img_size,
  output logic [FIELD_W-1:0]   o_oc_base,
  output logic [FIELD_W-1:0]   o_oc_num,
  output logic [IDX_W-1:0]     o_layer_idx,
  output logic                 o_layer_start,
  input  logic                 i_layer_done,
  output logic                 o_sps_part_done,
  output logic                 o_cfg_err,
  output state_t               o_state
);

  localparam logic [IDX_W:0] LAST_COUNT = (IDX_W+1)'(MAX_LAYERS);

  state_t             state_q, state_d;
  desc_t              desc_q;
  desc_t              desc_in;
  logic [IDX_W-1:0]   idx_q;
  logic               cfg_err_q;
  logic               handshake;
  logic               more_passes;
  logic               last_layer;

  assign desc_in = {code.i_is_maxpool, code.i_lif_thrd, code.i_bias_scale,
                    code.i_in_ch, code.i_out_ch, code.i_img_size};

  assign handshake  = (state_q == ST_REQ) && code.i_code_valid;
  assign last_layer = code.i_fetch_done || (({1'b0, idx_q} + 1'b1) == LAST_COUNT);

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q   <= ST_IDLE;
      desc_q    <= '0;
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && i_sps_start) begin
        idx_q     <= '0;
        cfg_err_q <= 1'b0;
      end
      if (handshake) begin
        desc_q <= desc_in;
        if (desc_invalid(desc_in)) begin
          cfg_err_q <= 1'b1;
        end
      end
      if (state_q == ST_CHECK) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    code.o_code_ready = 1'b0;
    o_layer_start     = 1'b0;
    o_sps_part_done   = 1'b0;
    o_busy            = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (i_sps_start) state_d = ST_REQ;
      end
      ST_REQ: begin
        code.o_code_ready = 1'b1;
        if (code.i_code_valid) begin
          state_d = desc_invalid(desc_in) ? ST_CHECK : ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        o_layer_start = 1'b1;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_layer_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        state_d = more_passes ? ST_LAUNCH : ST_CHECK;
      end
      ST_CHECK: begin
        state_d = last_layer ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        o_sps_part_done = 1'b1;
        state_d         = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  sps_layer_sequencer_oc_pass_ctrl #(
    .OC_PER_PASS (OC_PER_PASS)
  ) u_oc_pass_ctrl (
    .s_clk       (s_clk),
    .s_rst       (s_rst),
    .load        (handshake),
    .advance     (state_q == ST_NEXT),
    .is_maxpool  (desc_q.is_maxpool),
    .out_ch      (desc_q.out_ch),
    .oc_base     (o_oc_base),
    .oc_num      (o_oc_num),
    .more_passes (more_passes)
  );

  assign o_is_maxpool = desc_q.is_maxpool;
  assign o_lif_thrd   = desc_q.lif_thrd;
  assign o_bias_scale = desc_q.bias_scale;
  assign o_in_ch      = desc_q.in_ch;
  assign o_out_ch     = desc_q.out_ch;
  assign o_img_size   = desc_q.img_size;
  assign o_layer_idx  = idx_q;
  assign o_cfg_err    = cfg_err_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_sps_layer_sequencer.sv
// Bench for sps_layer_sequencer: code-fetch and engine responders, launch
// scoreboard fed from the descriptor list, timing and boundary checks.
module tb_sps_layer_sequencer;
  import sps_layer_sequencer_pkg::*;

  localparam int OC_PER_PASS = 8;
  localparam int MAX_LAYERS  = 32;
  localparam int W           = 118;

  logic          s_clk = 1'b0;
  logic          s_rst = 1'b1;
  logic          i_sps_start = 1'b0;
  logic          i_layer_done = 1'b0;
  logic          o_busy, o_is_maxpool, o_layer_start, o_sps_part_done, o_cfg_err;
  logic [15:0]   o_lif_thrd, o_bias_scale, o_in_ch, o_out_ch, o_img_size;
  logic [15:0]   o_oc_base, o_oc_num;
  logic [4:0]    o_layer_idx;
  state_t        o_state;

  sps_layer_sequencer_if code();

  sps_layer_sequencer #(
    .OC_PER_PASS (OC_PER_PASS),
    .MAX_LAYERS  (MAX_LAYERS)
  ) dut (
    .s_clk           (s_clk),
    .s_rst           (s_rst),
    .i_sps_start     (i_sps_start),
    .o_busy          (o_busy),
    .code            (code.slave),
    .o_is_maxpool    (o_is_maxpool),
    .o_lif_thrd      (o_lif_thrd),
    .o_bias_scale    (o_bias_scale),
    .o_in_ch         (o_in_ch),
    .o_out_ch        (o_out_ch),
    .o_img_size      (o_img_size),
    .o_oc_base       (o_oc_base),
    .o_oc_num        (o_oc_num),
    .o_layer_idx     (o_layer_idx),
    .o_layer_start   (o_layer_start),
    .i_layer_done    (i_layer_done),
    .o_sps_part_done (o_sps_part_done),
    .o_cfg_err       (o_cfg_err),
    .o_state         (o_state)
  );

  // Clock / cycle counter
  always #5 s_clk = ~s_clk;
  int cyc = 0;
  always @(posedge s_clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  desc_t        rom_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int launch_cnt = 0;
  int last_done_cyc = -100;
  int last_part_done_cyc = -100;
  int first_launch_cyc = -1;
  int cf_delay = 1;
  int cf_addr = 0;
  bit eng_hold = 1'b0;
  bit inject_req = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_desc(input desc_t d);
    code.i_is_maxpool = d.is_maxpool;
    code.i_lif_thrd   = d.lif_thrd;
    code.i_bias_scale = d.bias_scale;
    code.i_in_ch      = d.in_ch;
    code.i_out_ch     = d.out_ch;
    code.i_img_size   = d.img_size;
  endtask

  // Appends a descriptor and the engine launches it should produce.
  task automatic add_desc(input logic mp, input logic [15:0] inc, input logic [15:0] outc,
                          input logic [15:0] img, input logic [15:0] lif);
    desc_t d;
    int pos;
    int oc;
    pos = rom_q.size();
    oc  = int'(outc);
    d.is_maxpool = mp;
    d.lif_thrd   = lif;
    d.bias_scale = lif ^ 16'h5a5a;
    d.in_ch      = inc;
    d.out_ch     = outc;
    d.img_size   = img;
    rom_q.push_back(d);
    if (pos < MAX_LAYERS && inc != 0 && img != 0 && (mp || outc != 0)) begin
      if (mp) begin
        exp_q.push_back({5'(pos), 1'b1, 16'd0, outc, outc, lif, d.bias_scale, inc, img});
      end else begin
        for (int b = 0; b < oc; b += OC_PER_PASS) begin
          exp_q.push_back({5'(pos), 1'b0, 16'(b),
                           16'((oc - b < OC_PER_PASS) ? oc - b : OC_PER_PASS),
                           outc, lif, d.bias_scale, inc, img});
        end
      end
    end
  endtask

  // Launch monitor
  always @(negedge s_clk) begin
    if (o_layer_start) begin
      launch_cnt++;
      if (first_launch_cyc < 0) first_launch_cyc = cyc;
      if (o_oc_base != 16'd0) chk("pass_gap", W'(cyc - last_done_cyc), W'(2));
      if (exp_q.size() == 0) chk("extra_launch", W'(1), W'(0));
      else chk("launch", {o_layer_idx, o_is_maxpool, o_oc_base, o_oc_num, o_out_ch,
                          o_lif_thrd, o_bias_scale, o_in_ch, o_img_size}, exp_q.pop_front());
    end
    if (o_sps_part_done) begin
      done_cnt++;
      last_part_done_cyc = cyc;
    end
  end

  // Code-fetch responder: valid after cf_delay cycles of ready, then one
  // extra valid cycle after the handshake; fetch_done registered after the last.
  initial begin : code_fetch
    code.i_code_valid = 1'b0;
    code.i_fetch_done = 1'b0;
    drive_desc('0);
    forever begin
      @(posedge s_clk); #1;
      if (o_sps_part_done) begin
        cf_addr = 0;
        code.i_fetch_done = 1'b0;
      end else if (code.o_code_ready && !s_rst && cf_addr < rom_q.size()) begin
        for (int d = 0; d < cf_delay; d++) begin
          chk("ready_hold", W'(code.o_code_ready), W'(1));
          if (inject_req && d == 1) chk("inject_state", W'(o_state), W'(ST_REQ));
          if (inject_req && d == 0) begin i_sps_start = 1'b1; i_layer_done = 1'b1; end
          @(posedge s_clk); #1;
          if (inject_req && d == 0) begin i_sps_start = 1'b0; i_layer_done = 1'b0; end
        end
        drive_desc(rom_q[cf_addr]);
        code.i_code_valid = 1'b1;
        @(posedge s_clk); #1;
        cf_addr++;
        if (cf_addr == rom_q.size()) code.i_fetch_done = 1'b1;
        @(posedge s_clk); #1;
        code.i_code_valid = 1'b0;
      end
    end
  end

  // Engine responder
  initial begin : engine
    forever begin
      @(posedge s_clk); #1;
      if (o_layer_start && !eng_hold) begin
        repeat ($urandom_range(1, 4)) begin @(posedge s_clk); #1; end
        i_layer_done  = 1'b1;
        last_done_cyc = cyc;
        @(posedge s_clk); #1;
        i_layer_done  = 1'b0;
      end
    end
  end

  task automatic fetch_reset();
    cf_addr = 0;
    code.i_code_valid = 1'b0;
    code.i_fetch_done = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, W'({o_busy, code.o_code_ready, o_layer_start, o_sps_part_done, o_cfg_err}), W'(0));
    chk({tag, "_idx"}, W'(o_layer_idx), W'(0));
    chk({tag, "_oc"}, W'({o_oc_base, o_oc_num}), W'(0));
    chk({tag, "_desc"}, W'({o_is_maxpool, o_lif_thrd, o_bias_scale, o_in_ch, o_out_ch, o_img_size}), W'(0));
    chk({tag, "_state"}, W'(o_state), W'(ST_IDLE));
  endtask

  task automatic pulse_start(output int start_cyc);
    @(posedge s_clk); #1;
    i_sps_start = 1'b1;
    start_cyc   = cyc;
    @(posedge s_clk); #1;
    i_sps_start = 1'b0;
  endtask

  task automatic run(input string tag, input bit chk_lat);
    int start_cyc;
    int d0;
    int budget;
    d0 = done_cnt;
    first_launch_cyc = -1;
    pulse_start(start_cyc);
    chk({tag, "_busy_c1"}, W'(o_busy), W'(1));
    chk({tag, "_ready_c1"}, W'(code.o_code_ready), W'(1));
    chk({tag, "_err_clr"}, W'(o_cfg_err), W'(0));
    chk({tag, "_idx_clr"}, W'(o_layer_idx), W'(0));
    budget = 0;
    while (done_cnt == d0 && budget < 5000) begin
      @(posedge s_clk); #1;
      budget++;
    end
    chk({tag, "_done"}, W'(done_cnt - d0), W'(1));
    chk({tag, "_busy_end"}, W'(o_busy), W'(0));
    if (chk_lat) chk({tag, "_launch_lat"}, W'(first_launch_cyc - start_cyc), W'(2 + cf_delay));
    chk({tag, "_leftover"}, W'(exp_q.size()), W'(0));
    repeat (3) begin @(posedge s_clk); #1; end
    chk({tag, "_one_pulse"}, W'(done_cnt - d0), W'(1));
    rom_q.delete();
    exp_q.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int sc;
    int budget;
    int d0;
    fetch_reset();
    repeat (2) @(posedge s_clk);
    #1;
    s_rst = 1'b0;
    check_zero("rst");

    // layer_done in IDLE is ignored
    i_layer_done = 1'b1;
    @(posedge s_clk); #1;
    i_layer_done = 1'b0;
    chk("idle_done_state", W'(o_state), W'(ST_IDLE));
    @(posedge s_clk); #1;
    chk("idle_no_launch", W'(launch_cnt), W'(0));

    // three conv layers: 2, 1 and 3 passes
    cf_delay = 1;
    add_desc(1'b0, 16'd3, 16'd16, 16'd32, 16'h0100);
    add_desc(1'b0, 16'd16, 16'd8, 16'd16, 16'h0200);
    add_desc(1'b0, 16'd8, 16'd20, 16'd8, 16'h0300);
    run("conv3", 1'b1);
    chk("conv3_done_lat", W'(last_part_done_cyc - last_done_cyc), W'(3));
    chk("conv3_launches", W'(launch_cnt), W'(6));
    chk("conv3_idx", W'(o_layer_idx), W'(3));

    // single maxpool layer
    add_desc(1'b1, 16'd64, 16'd64, 16'd16, 16'h0400);
    run("maxpool", 1'b1);

    // delayed code fetch with start/layer_done injected during REQ
    cf_delay   = 6;
    inject_req = 1'b1;
    add_desc(1'b0, 16'd4, 16'd8, 16'd4, 16'h0500);
    run("delay", 1'b1);
    inject_req = 1'b0;
    cf_delay   = 1;

    // invalid descriptors are skipped and flagged
    add_desc(1'b0, 16'd2, 16'd8, 16'd4, 16'h0600);
    add_desc(1'b0, 16'd0, 16'd8, 16'd4, 16'h0601);
    add_desc(1'b1, 16'd2, 16'd8, 16'd0, 16'h0602);
    add_desc(1'b0, 16'd2, 16'd0, 16'd4, 16'h0603);
    add_desc(1'b0, 16'd2, 16'd12, 16'd4, 16'h0604);
    run("cfg_err", 1'b1);
    chk("cfg_err_set", W'(o_cfg_err), W'(1));
    chk("cfg_err_idx", W'(o_layer_idx), W'(5));

    // descriptor bound stops the run before fetch_done
    for (int i = 0; i < MAX_LAYERS + 2; i++) add_desc(1'b0, 16'd1, 16'd8, 16'd1, 16'(i + 1));
    run("max_layers", 1'b1);
    chk("max_layers_idx", W'(o_layer_idx), W'(0));

    // reset while waiting for the engine
    eng_hold = 1'b1;
    d0 = done_cnt;
    add_desc(1'b0, 16'd3, 16'd16, 16'd8, 16'h0700);
    pulse_start(sc);
    budget = 0;
    while (o_state != ST_WAIT && budget < 50) begin
      @(posedge s_clk); #1;
      budget++;
    end
    chk("reach_wait", W'(o_state), W'(ST_WAIT));
    s_rst = 1'b1;
    @(posedge s_clk); #1;
    check_zero("rst_wait");
    s_rst = 1'b0;
    fetch_reset();
    repeat (4) begin @(posedge s_clk); #1; end
    chk("rst_no_part_done", W'(done_cnt - d0), W'(0));
    eng_hold = 1'b0;
    rom_q.delete();
    exp_q.delete();

    // fresh run after reset
    add_desc(1'b0, 16'd5, 16'd20, 16'd8, 16'h0800);
    run("post_rst", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
